// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: operand width, FSM states
// and the Booth operation decoded from the {mq[0], q_m1} pair.
package mult_pkg;

  localparam int MULT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth: 01 ends a run of ones (add), 10 starts one (subtract).
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: optional add/subtract of the multiplicand into
// the upper partial product, then arithmetic right shift of {acc, mq, q_m1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_mq,
  input  logic             i_q_m1,
  input  logic [WIDTH:0]   i_mcand,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_mq,
  output logic             o_q_m1
);

  booth_op_t        w_op;
  logic [WIDTH:0]   w_sum;

  assign w_op = booth_decode({i_mq[0], i_q_m1});

  always_comb begin
    w_sum = i_acc;
    case (w_op)
      ADD:     w_sum = i_acc + i_mcand;
      SUB:     w_sum = i_acc - i_mcand;
      default: w_sum = i_acc;
    endcase
  end

  // acc is one bit wider than the operands, so the shift keeps its sign exact.
  assign o_acc  = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_mq   = {w_sum[0], i_mq[WIDTH-1:1]};
  assign o_q_m1 = i_mq[0];

endmodule

// File: rtl/booth_mult.sv
// Sequential signed radix-2 Booth multiplier with start/busy/done handshake.
// Optional BOOTH_MULT_ZERO_SKIP_EN: a zero operand completes on the start edge.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_z,
  output logic               o_busy,
  output logic               o_done,
  output mult_state_t        o_state
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  // Handshake: i_start is a level sampled every edge and always wins, aborting
  // any run; o_busy is high while iterating; o_done pulses for one cycle when
  // o_z takes a new product. o_z holds between completions.
  mult_state_t        r_state;
  mult_state_t        w_state_n;
  logic               w_finish;
  logic               w_zero;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic               r_q_m1;
  logic [WIDTH:0]     r_mcand;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_z;
  logic               r_done;
  logic [WIDTH:0]     w_acc_n;
  logic [WIDTH-1:0]   w_mq_n;
  logic               w_q_m1_n;

`ifdef BOOTH_MULT_ZERO_SKIP_EN
  assign w_zero = (i_a == '0) || (i_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc   (r_acc),
    .i_mq    (r_mq),
    .i_q_m1  (r_q_m1),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_n),
    .o_mq    (w_mq_n),
    .o_q_m1  (w_q_m1_n)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_finish  = 1'b0;
    if (i_start) begin
      w_state_n = w_zero ? IDLE : RUN;
    end else if (r_state == RUN && r_count == LAST) begin
      w_state_n = IDLE;
      w_finish  = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_mq    <= '0;
      r_q_m1  <= 1'b0;
      r_mcand <= '0;
      r_count <= '0;
      r_z     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc   <= '0;
        r_mq    <= i_b;
        r_q_m1  <= 1'b0;
        r_mcand <= {i_a[WIDTH-1], i_a};
        r_count <= '0;
        if (w_zero) begin
          r_z    <= '0;
          r_done <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_acc   <= w_acc_n;
        r_mq    <= w_mq_n;
        r_q_m1  <= w_q_m1_n;
        r_count <= r_count + CW'(1);
        if (w_finish) begin
          r_z    <= {w_acc_n[WIDTH-1:0], w_mq_n};
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_z     = r_z;
  assign o_busy  = (r_state == RUN);
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: tb/tb_booth_mult.sv
// Directed and random checks of booth_mult against a plain signed-multiply
// reference, including restart, reset-abort and start-on-final-iteration.
module tb_booth_mult;
  import mult_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic [63:0] o_z;
  logic        o_busy;
  logic        o_done;
  mult_state_t o_state;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_z = '0;

  booth_mult dut (
    .clock   (clock),
    .reset   (reset),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_z     (o_z),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_state (o_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic bit zero_skip(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_MULT_ZERO_SKIP_EN
    return (a == 32'd0) || (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Launch one multiply and follow it to completion.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit skip;
    skip = zero_skip(a, b);
    exp_q.push_back(ref_mul(a, b));
    i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_a = $urandom; i_b = $urandom;
    check({tag, "_busy"}, 64'(o_busy), skip ? 64'd0 : 64'd1);
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), skip ? 64'd0 : 64'd32);
    exp_z = exp_q.pop_front();
    check({tag, "_z"}, o_z, exp_z);
    tick();
    check({tag, "_done_pulse"}, 64'(o_done), 64'd0);
    check({tag, "_z_hold"}, o_z, exp_z);
  endtask

  initial begin
    int n;
    int seen;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    check("reset_z", o_z, 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_state", 64'(o_state), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Directed products and boundaries
    do_op("7x-3", 32'd7, 32'hFFFF_FFFD);
    check("7x-3_const", o_z, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("minxmin", 32'h8000_0000, 32'h8000_0000);
    check("minxmin_const", o_z, 64'h4000_0000_0000_0000);
    do_op("minx-1", 32'h8000_0000, 32'hFFFF_FFFF);
    check("minx-1_const", o_z, 64'h0000_0000_8000_0000);
    do_op("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check("maxxmax_const", o_z, 64'h3FFF_FFFF_0000_0001);
    do_op("0xk", 32'd0, 32'h1234_5678);
    do_op("kx0", 32'hDEAD_BEEF, 32'd0);

    // Random operands
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'(int'($urandom_range(0, 15)) - 8);
      do_op("rand", ra, rb);
    end

    // Restart mid-run: only the second operation completes
    i_a = 32'd5; i_b = 32'd6; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (o_done) seen++;
    end
    i_a = 32'd9; i_b = 32'hFFFF_FFFE; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    check("restart_no_early_done", 64'(seen), 64'd0);
    check("restart_latency", 64'(n), 64'd32);
    exp_z = ref_mul(32'd9, 32'hFFFF_FFFE);
    check("restart_z", o_z, exp_z);
    check("restart_z_const", o_z, 64'hFFFF_FFFF_FFFF_FFEE);
    tick();
    check("restart_done_pulse", 64'(o_done), 64'd0);

    // Reset mid-run abandons the multiply
    i_a = 32'd3; i_b = 32'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    reset = 1'b1;
    #1;
    check("midreset_busy", 64'(o_busy), 64'd0);
    check("midreset_z", o_z, 64'd0);
    check("midreset_done", 64'(o_done), 64'd0);
    tick();
    reset = 1'b0;
    exp_z = '0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_done) seen++;
    end
    check("midreset_no_done", 64'(seen), 64'd0);
    check("midreset_z_after", o_z, exp_z);

    // Start on the final iteration: restart wins, z untouched
    do_op("pre_collide", 32'd11, 32'd13);
    i_a = 32'd100; i_b = 32'hFFFF_FFF9; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (o_done) seen++;
    end
    i_a = 32'd4; i_b = 32'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("collide_early_done", 64'(seen), 64'd0);
    check("collide_done", 64'(o_done), 64'd0);
    check("collide_z_kept", o_z, exp_z);
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
    check("collide_latency", 64'(n), 64'd32);
    exp_z = ref_mul(32'd4, 32'd5);
    check("collide_z", o_z, exp_z);
    tick();

    // Held start never completes
    i_a = 32'd2; i_b = 32'd3; i_start = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_done) seen++;
    end
    i_start = 1'b0;
    check("held_start_no_done", 64'(seen), 64'd0);
    check("held_start_z", o_z, exp_z);
    do_op("after_hold", 32'hFFFF_FF00, 32'd77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential signed multiplier that completes the integer datapath's multiply/divide pair. It uses radix-2 Booth recoding. It takes two 32-bit two's-complement operands on a `start` pulse and produces the full 64-bit signed product after a fixed iteration count. Its handshake matches the existing divider (`start`/`busy`), so the execute stage drives both units the same way.

## Interface
- `WIDTH`, 32: operand width. The product is 2×WIDTH.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `start`  in  1: launch a multiply; operands are sampled on this edge.
- `a`  in  WIDTH: multiplicand, signed.
- `b`  in  WIDTH: multiplier, signed.
- `z`  out  2×WIDTH: signed product, registered.
- `busy`  out  1: iteration in progress.
- `done`  out  1: one-cycle pulse when `z` becomes valid.

## Operation
- Registers:
  - `acc`: WIDTH+1 bits, the upper partial product, kept sign-extended so adding or subtracting −2^(WIDTH−1) cannot overflow.
  - `mq`: WIDTH bits, holds the multiplier and fills with the lower product bits.
  - `q_m1`: 1 bit, Booth history bit.
  - `mcand`: WIDTH+1 bits, sign-extended copy of `a`.
  - `count`: clog2(WIDTH) bits.
- States: IDLE, RUN.
- Start, accepted in any state:
  - `acc`←0, `mq`←`b`, `q_m1`←0, `mcand`←sext(`a`), `count`←0.
  - `busy`←1, `done`←0, state→RUN.
- RUN, each cycle:
  - Booth pair {`mq[0]`,`q_m1`}: 01 → `acc`+`mcand`; 10 → `acc`−`mcand`; 00 or 11 → no change.
  - Then arithmetic right shift of {`acc`,`mq`,`q_m1`} by one.
  - `count`++.
- Finish: on the iteration where `count`==WIDTH−1:
  - `z`←{new `acc`[WIDTH−1:0], new `mq`}.
  - `busy`←0, `done`←1, state→IDLE.
- `z` holds its value until the next completion. It is not cleared by `start`.
- `start` while busy aborts the current operation and restarts with the new operands. The aborted operation never produces `done`.
- `start` in the same cycle as the final iteration: the restart wins. `z` is not updated and `done` stays 0.
- All operand combinations are exact. This includes −2^31×−2^31 = +2^62 and −2^31×−1 = +2^31. There is no overflow flag.

## Timing
- Reset values:
  - Outputs: `z`=0, `busy`=0, `done`=0.
  - Internal: state=IDLE, `count`=0, `acc`=0, `mq`=0, `q_m1`=0.
- Reset mid-operation abandons the multiply immediately. No `done` is produced.
- `start` sampled at edge k:
  - `busy`=1 after edge k.
  - Iterations run at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: `busy`=0, `done`=1, `z` valid.
  - After edge k+WIDTH+1: `done`=0.
- Latency is 32 cycles from `start` to `done` for WIDTH=32.
- `start` is a level sampled each edge. Holding it high restarts continuously, so no result is produced.
- `a` and `b` are don't-care except on the `start` edge.

## Configuration
- Macro: `BOOTH_MULT_ZERO_SKIP_EN`.
- Defined: if `a`==0 or `b`==0 on the `start` edge:
  - `z`←0 and `done`←1 at that edge.
  - `busy` stays 0 and state stays IDLE.
  - Latency is 1 cycle.
- Undefined: every operation takes WIDTH iterations regardless of operand values.
- The interface is identical in both builds.

## Structure
- Package `mult_pkg`:
  - `MULT_W` = 32.
  - State enum `mult_state_t` {IDLE, RUN}.
  - Booth op enum {NOP, ADD, SUB}, decoded from the 2-bit pair.
- Sub-module `booth_step`, purely combinational:
  - Inputs: `acc`, `mq`, `q_m1`, `mcand`.
  - Outputs: next `acc`, `mq`, `q_m1`, i.e. one add/sub plus shift.
  - `booth_mult` instantiates it once and owns the counter, FSM and output register.

## Test plan
- 7 × −3 → `z`=0xFFFFFFFF_FFFFFFEB; `done` exactly 32 cycles after `start`, single-cycle.
- 0x80000000 × 0x80000000 → `z`=0x40000000_00000000.
- 0x80000000 × 0xFFFFFFFF → `z`=0x00000000_80000000.
- 0x7FFFFFFF × 0x7FFFFFFF → `z`=0x3FFFFFFF_00000001.
- Restart and reset:
  - Start 5×6, then re-start with 9×−2 at cycle 10 → exactly one `done`, 32 cycles after the re-start, `z`=0xFFFFFFFF_FFFFFFEE.
  - Assert `reset` at cycle 15 of another run → `busy`=0, `z`=0, no `done`.
- 0 × 0x12345678 → `z`=0, `done` at cycle 32 without the macro; `done` at the start edge with `BOOTH_MULT_ZERO_SKIP_EN`.
